// File: rtl/axi_lite_reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_reg_file_pkg
// Description : Shared types and constants for the AXI4-Lite register file:
//               response codes, default AXI4-Lite request/response structs
//               and an index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_reg_file_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned c_DEF_ADDR_WIDTH = 32;
    localparam int unsigned c_DEF_DATA_WIDTH = 32;

    typedef struct packed {
        logic [c_DEF_ADDR_WIDTH-1:0] addr;
        logic [2:0]                  prot;
    } axi_lite_ax_t;

    typedef struct packed {
        logic [c_DEF_DATA_WIDTH-1:0]   data;
        logic [c_DEF_DATA_WIDTH/8-1:0] strb;
    } axi_lite_w_t;

    typedef struct packed {
        logic [1:0] resp;
    } axi_lite_b_t;

    typedef struct packed {
        logic [c_DEF_DATA_WIDTH-1:0] data;
        logic [1:0]                  resp;
    } axi_lite_r_t;

    typedef struct packed {
        axi_lite_ax_t aw;
        logic         aw_valid;
        axi_lite_w_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_lite_ax_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_lite_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        axi_lite_b_t b;
        logic        b_valid;
        logic        ar_ready;
        axi_lite_r_t r;
        logic        r_valid;
    } axi_lite_resp_t;

    // Index field width; a single register still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_reg_file_hold.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_reg_file_hold
// Description : One-entry holding buffer for an AXI4-Lite AW or W beat that
//               arrives before its partner. Clear wins over push so a beat
//               consumed in the same cycle it arrives is never held.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_reg_file_hold #(
    parameter int unsigned WIDTH = 32
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_held,
    output logic [WIDTH-1:0] o_data
);

    logic             r_held;
    logic [WIDTH-1:0] r_data;

    // Occupancy flag and captured payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_held <= 1'b0;
            r_data <= '0;
        end else begin
            if (i_clear) begin
                r_held <= 1'b0;
            end else if (i_push) begin
                r_held <= 1'b1;
            end
            if (i_push) begin
                r_data <= i_data;
            end
        end
    end

    assign o_held = r_held;
    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/axi_lite_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_reg_file
// Description : AXI4-Lite register file endpoint. NUM_REGS registers with
//               byte-strobed bus writes, per-register hardware loads, parallel
//               read-out and a one-cycle write pulse per register.
//               Optional feature macro: AXI_LITE_REG_FILE_DECERR_EN
//               (defined: out-of-range word index answers DECERR;
//                undefined: index wraps modulo NUM_REGS, always OKAY).
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_reg_file
    import axi_lite_reg_file_pkg::*;
#(
    parameter int unsigned NUM_REGS       = 8,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter type         REQ_T          = axi_lite_req_t,
    parameter type         RESP_T         = axi_lite_resp_t,
    parameter logic [NUM_REGS-1:0][AXI_DATA_WIDTH-1:0] REG_RST_VAL = '0
)(
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  REQ_T                                    slv_req_i,
    output RESP_T                                   slv_resp_o,
    output logic [NUM_REGS-1:0][AXI_DATA_WIDTH-1:0] reg_q_o,
    input  logic [NUM_REGS-1:0]                     reg_load_i,
    input  logic [NUM_REGS-1:0][AXI_DATA_WIDTH-1:0] reg_d_i,
    output logic [NUM_REGS-1:0]                     wr_pulse_o
);

    localparam int unsigned c_STRB_W   = AXI_DATA_WIDTH / 8;
    localparam int unsigned c_ADDR_LSB = $clog2(c_STRB_W);
    localparam int unsigned c_IDX_W    = idx_width(NUM_REGS);

    typedef logic [c_IDX_W-1:0]        idx_t;
    typedef logic [AXI_ADDR_WIDTH-1:0] addr_t;
    typedef logic [AXI_DATA_WIDTH-1:0] data_t;
    typedef logic [c_STRB_W-1:0]       strb_t;

    // Word index, wrapped into the register range.
    function automatic idx_t f_idx(input addr_t a);
        logic [31:0] raw;
        raw = 32'(a[c_ADDR_LSB +: c_IDX_W]);
        return idx_t'(raw % NUM_REGS);
    endfunction

    logic [NUM_REGS-1:0][AXI_DATA_WIDTH-1:0] r_regs;
    logic [NUM_REGS-1:0] r_wr_pulse;
    logic                r_b_valid;
    logic [1:0]          r_b_resp;
    logic                r_r_valid;
    logic [1:0]          r_r_resp;
    data_t               r_r_data;

    logic  w_aw_held, w_w_held;
    addr_t w_aw_hold_q;
    data_t w_w_hold_data;
    strb_t w_w_hold_strb;
    logic  w_aw_ready, w_w_ready, w_ar_ready;
    logic  w_aw_fire, w_w_fire, w_ar_fire, w_commit;
    addr_t w_wr_addr, w_rd_addr;
    data_t w_wr_data;
    strb_t w_wr_strb;
    idx_t  w_wr_idx, w_rd_idx;
    logic  w_wr_err, w_rd_err;
    logic [NUM_REGS-1:0] w_wr_hit;
    logic  w_unused;

    assign w_aw_ready = !w_aw_held && !r_b_valid;
    assign w_w_ready  = !w_w_held && !r_b_valid;
    assign w_ar_ready = !r_r_valid || slv_req_i.r_ready;
    assign w_aw_fire  = slv_req_i.aw_valid && w_aw_ready;
    assign w_w_fire   = slv_req_i.w_valid && w_w_ready;
    assign w_ar_fire  = slv_req_i.ar_valid && w_ar_ready;
    assign w_commit   = (w_aw_held || w_aw_fire) && (w_w_held || w_w_fire);

    axi_lite_reg_file_hold #(.WIDTH(AXI_ADDR_WIDTH)) u_aw_hold (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (w_aw_fire),
        .i_clear (w_commit),
        .i_data  (addr_t'(slv_req_i.aw.addr)),
        .o_held  (w_aw_held),
        .o_data  (w_aw_hold_q)
    );

    axi_lite_reg_file_hold #(.WIDTH(AXI_DATA_WIDTH + c_STRB_W)) u_w_hold (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (w_w_fire),
        .i_clear (w_commit),
        .i_data  ({data_t'(slv_req_i.w.data), strb_t'(slv_req_i.w.strb)}),
        .o_held  (w_w_held),
        .o_data  ({w_w_hold_data, w_w_hold_strb})
    );

    assign w_wr_addr = w_aw_held ? w_aw_hold_q   : addr_t'(slv_req_i.aw.addr);
    assign w_wr_data = w_w_held  ? w_w_hold_data : data_t'(slv_req_i.w.data);
    assign w_wr_strb = w_w_held  ? w_w_hold_strb : strb_t'(slv_req_i.w.strb);
    assign w_rd_addr = addr_t'(slv_req_i.ar.addr);
    assign w_wr_idx  = f_idx(w_wr_addr);
    assign w_rd_idx  = f_idx(w_rd_addr);

`ifdef AXI_LITE_REG_FILE_DECERR_EN
    // Out of range means the full word address (all bits above the byte
    // offset) lies beyond the last register, so aliases are rejected too.
    function automatic logic f_oor(input addr_t a);
        return (a >> c_ADDR_LSB) >= addr_t'(NUM_REGS);
    endfunction
    assign w_wr_err = f_oor(w_wr_addr);
    assign w_rd_err = f_oor(w_rd_addr);
`else
    assign w_wr_err = 1'b0;
    assign w_rd_err = 1'b0;
`endif

    // One-hot target of a committing, in-range write.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_hit
            assign w_wr_hit[gi] = w_commit && !w_wr_err && (w_wr_idx == idx_t'(gi));
        end
    endgenerate

    // Register storage: strobed bus bytes beat hardware load, others may load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_regs     <= REG_RST_VAL;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= w_wr_hit;
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int k = 0; k < c_STRB_W; k++) begin
                    if (w_wr_hit[i] && w_wr_strb[k]) begin
                        r_regs[i][8*k +: 8] <= w_wr_data[8*k +: 8];
                    end else if (reg_load_i[i]) begin
                        r_regs[i][8*k +: 8] <= reg_d_i[i][8*k +: 8];
                    end
                end
            end
        end
    end

    // Write response channel: raised on commit, held until accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_b_valid <= 1'b0;
            r_b_resp  <= 2'b00;
        end else if (w_commit) begin
            r_b_valid <= 1'b1;
            r_b_resp  <= w_wr_err ? RESP_DECERR : RESP_OKAY;
        end else if (slv_req_i.b_ready) begin
            r_b_valid <= 1'b0;
        end
    end

    // Read response channel: captures pre-edge register value on AR handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_r_valid <= 1'b0;
            r_r_data  <= '0;
            r_r_resp  <= 2'b00;
        end else if (w_ar_fire) begin
            r_r_valid <= 1'b1;
            r_r_data  <= w_rd_err ? '0 : r_regs[w_rd_idx];
            r_r_resp  <= w_rd_err ? RESP_DECERR : RESP_OKAY;
        end else if (slv_req_i.r_ready) begin
            r_r_valid <= 1'b0;
        end
    end

    // Response struct assembly.
    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = w_aw_ready;
        slv_resp_o.w_ready  = w_w_ready;
        slv_resp_o.b_valid  = r_b_valid;
        slv_resp_o.b.resp   = r_b_resp;
        slv_resp_o.ar_ready = w_ar_ready;
        slv_resp_o.r_valid  = r_r_valid;
        slv_resp_o.r.data   = r_r_data;
        slv_resp_o.r.resp   = r_r_resp;
    end

    assign reg_q_o    = r_regs;
    assign wr_pulse_o = r_wr_pulse;

    // Protection bits and address bits outside the decode are ignored.
    assign w_unused = ^{slv_req_i.aw, slv_req_i.ar, w_aw_hold_q, w_wr_addr, w_rd_addr};

endmodule
`default_nettype wire

// File: doc/axi_lite_reg_file.md
# axi_lite_reg_file

Memory-mapped AXI4-Lite register file endpoint that sits directly on one master port of the AXI4-Lite crossbar and consumes the requests that port's multiplexer produces. It holds `NumRegs` registers of `AxiDataWidth` bits, each writable from the bus with byte strobes and loadable from hardware. It exposes all register values in parallel to surrounding logic. Every accepted transaction receives exactly one single-beat B or R response.

## Interface
Reset is synchronous and active-high on a single clock.

Parameters:
- `NumRegs`, 8: number of registers, ≥1.
- `AxiAddrWidth`, 32: AW/AR address width.
- `AxiDataWidth`, 32: data width; 32 or 64.
- `req_t`, logic: AXI4-Lite request struct with aw, w, ar, valids and b_ready, r_ready.
- `resp_t`, logic: AXI4-Lite response struct with readies, b, r, valids.
- `RegRstVal`, '0: `[NumRegs-1:0][AxiDataWidth-1:0]` reset value per register.

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  synchronous active-high reset
- `slv_req_i`  in  req_t  AXI4-Lite request from the crossbar master port
- `slv_resp_o`  out  resp_t  AXI4-Lite response
- `reg_q_o`  out  NumRegs×AxiDataWidth  current register contents
- `reg_load_i`  in  NumRegs  per-register hardware load enable
- `reg_d_i`  in  NumRegs×AxiDataWidth  hardware load data
- `wr_pulse_o`  out  NumRegs  one-cycle pulse, asserted in the cycle after a bus write commits to that register

## Operation
- Index decode: `AddrLsb = $clog2(AxiDataWidth/8)`, `IdxW = max(1,$clog2(NumRegs))`, idx = `addr[AddrLsb +: IdxW]`. Bits below AddrLsb are ignored. Bits above the index field are also ignored.
- Write path: AW and W each have an independent one-entry holding buffer.
  - `aw_ready = !aw_held && !b_valid`.
  - `w_ready = !w_held && !b_valid`.
- Write commit: occurs on the clock edge ending the cycle in which both AW and W are available. Each is available if held, or if handshaking in that cycle.
  - Per byte lane with `w.strb[k]=1`, the register byte is updated.
  - Both holds are cleared, `b_valid` is set with `b.resp=OKAY`, and the target's `wr_pulse_o` is set.
- B completion: `b_valid` clears on `b_valid && b_ready`. A new AW/W can be accepted in the next cycle.
- Read path:
  - `ar_ready = !r_valid || r_ready`.
  - On AR handshake, `r.data` is captured from the register, `r.resp=OKAY`, and `r_valid` is set.
- Priority on the same register in the same edge: bus write beats `reg_load_i` for strobed bytes. Non-strobed bytes take `reg_d_i` if loaded.
- Same-edge read and commit on the same register: R returns the old value.
- Reset mid-operation: holds, B and R pending are dropped, registers go to `RegRstVal`, and no response is issued for dropped transactions.

## Timing
- Reset values:
  - `b_valid=0`, `r_valid=0`, `b.resp=0`, `r.data=0`, `r.resp=0`, `wr_pulse_o=0`.
  - `reg_q_o=RegRstVal`.
  - `aw_ready=w_ready=ar_ready=1` in the first cycle after reset deasserts.
- AW and W handshake in cycle N: `b_valid`, the updated `reg_q_o` and `wr_pulse_o` appear in N+1.
- AW in N, W in N+k: response in N+k+1.
- Write throughput: 1 per 2 cycles with `b_ready` held high.
- Read: AR in N gives `r_valid` in N+1.
- Read throughput: 1 per cycle with `r_ready` held high.
- `reg_load_i` in N: `reg_q_o` is updated in N+1.
- Once asserted, B and R valid plus their payload stay stable until the handshake completes.

## Configuration
- `AXI_LITE_REG_FILE_DECERR_EN` defined: an index ≥ NumRegs yields `resp=DECERR` (2'b11).
  - Such a write changes no register and raises no pulse.
  - Such a read returns `r.data='0`.
- Macro undefined: the index is taken modulo NumRegs, i.e. the wrapped index selects the register. The response is always OKAY.

## Structure
- `RESP_OKAY`/`RESP_DECERR` come from `axi_pkg`.
- req/resp structs are built with the `axi/typedef.svh` macros.
- `AddrLsb`, `IdxW` and the index typedef are local localparams.
- One natural sub-module: `axi_lite_reg_file_hold`, a one-entry holding buffer instantiated for AW and for W.

## Test plan
- Reset, then AR addr 0x4 with NumRegs=8 and RegRstVal[1]=0xA5A5_0001 → R in next cycle with data 0xA5A5_0001 and OKAY.
- AW 0x8 in cycle 2, W data 0x1122_3344 with strb 4'b0101 in cycle 5, over reg2=0 → B OKAY in cycle 6, reg_q_o[2]=0x0022_0044, wr_pulse_o[2] high for one cycle.
- AW+W to 0x0 with data 0xFFFF_FFFF and strb 4'b1111, plus same-edge reg_load_i[0]=1 with reg_d_i=0x1234 → reg_q_o[0]=0xFFFF_FFFF. A same-edge AR 0x0 returns the old value.
- b_ready held low 5 cycles → b_valid and resp stable, aw_ready=w_ready=0 throughout. A new write is accepted the cycle after the handshake.
- Write/read to 0x40 with NumRegs=8:
  - With the macro defined → DECERR, no register change, r.data=0.
  - Without the macro → register 0 written or read, OKAY.
- rst_i asserted while b_valid pending and AW held → next cycle b_valid=0, aw_ready=1, registers = RegRstVal.
